// File: rtl/temporizador_pkg.sv
// Shared definitions for the temporizador timer controller.
// Holds the FSM state encoding exposed on the 'state' output and the
// default datapath widths used by the controller and its prescaler.
package temporizador_pkg;

  localparam int STATE_W     = 2;
  localparam int CNT_W_DEF   = 32;
  localparam int PRESC_W_DEF = 16;

  // Encoding is visible to software through the 'state' port, so it is fixed.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/temporizador_presc.sv
// Clock prescaler for the timer.
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous reset, active low
//   ena   - advance the divider this clock (controller is in RUN)
//   clr   - synchronous clear back to phase 0 (start/stop)
//   presc - divide value; one tick every presc+1 enabled clocks
//   tick  - combinational strobe, high on the enabled clock that ends a division
module temporizador_presc
  import temporizador_pkg::*;
#(
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] count;

  // The tick is taken from the current phase so presc=0 ticks on every enabled clock.
  assign tick = ena && (count == presc);

  // Phase counter: wraps to zero on the ticking clock, frozen while not enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (ena) begin
      if (count == presc) begin
        count <= '0;
      end else begin
        count <= count + PRESC_W'(1);
      end
    end
  end

endmodule

// File: rtl/temporizador_ctrl.sv
// Programmable timer controller: sequences a up/down counter with a prescaler.
// Supports one-shot and periodic (auto-reload) modes, pause/hold, a one-clock
// terminal-count pulse and a sticky interrupt flag.
// Ports:
//   clk, rst        - clock and asynchronous active-low reset
//   start, stop     - pulses; start latches config and runs, stop aborts (stop wins)
//   pause           - level; freezes the count while running
//   periodic,dir_up - mode and direction, latched on start
//   period, presc   - terminal value and prescaler divide, latched on start
//   irq_clr         - pulse; clears irq (a simultaneous terminal keeps it set)
//   cnt             - current count
//   state           - IDLE=0 RUN=1 HOLD=2 DONE=3
//   busy            - state is RUN or HOLD
//   tc_pulse        - one clock per terminal count
//   irq             - sticky terminal flag
module temporizador_ctrl
  import temporizador_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               periodic,
  input  logic               dir_up,
  input  logic [CNT_W-1:0]   period,
  input  logic [PRESC_W-1:0] presc,
  input  logic               irq_clr,
  output logic [CNT_W-1:0]   cnt,
  output logic [STATE_W-1:0] state,
  output logic               busy,
  output logic               tc_pulse,
  output logic               irq
);

  state_t             state_q;
  logic [CNT_W-1:0]   period_q;
  logic [PRESC_W-1:0] presc_q;
  logic               periodic_q;
  logic               dir_up_q;
  logic               tick;
  logic               presc_ena;
  logic               presc_clr;
  logic               at_term;

  // The prescaler only runs in RUN; the clock that enters HOLD still advances,
  // and the frozen phase is resumed when the pause is released.
  assign presc_ena = (state_q == ST_RUN);
  assign presc_clr = start | stop;

  // Terminal is checked before stepping, so the count never wraps.
  assign at_term = dir_up_q ? (cnt == period_q) : (cnt == '0);

  assign state = state_q;

  temporizador_presc #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk   (clk),
    .rst   (rst),
    .ena   (presc_ena),
    .clr   (presc_clr),
    .presc (presc_q),
    .tick  (tick)
  );

  // Controller FSM, count register, shadow config and registered flags.
  // irq_clr is applied first so a terminal on the same clock overrides it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      tc_pulse   <= 1'b0;
      irq        <= 1'b0;
      period_q   <= '0;
      presc_q    <= '0;
      periodic_q <= 1'b0;
      dir_up_q   <= 1'b0;
    end else begin
      tc_pulse <= 1'b0;
      if (irq_clr) begin
        irq <= 1'b0;
      end
      if (stop) begin
        state_q <= ST_IDLE;
        busy    <= 1'b0;
      end else if (start) begin
        period_q   <= period;
        presc_q    <= presc;
        periodic_q <= periodic;
        dir_up_q   <= dir_up;
        cnt        <= dir_up ? '0 : period;
        state_q    <= ST_RUN;
        busy       <= 1'b1;
      end else begin
        case (state_q)
          ST_RUN: begin
            if (tick && at_term) begin
              tc_pulse <= 1'b1;
              irq      <= 1'b1;
              if (periodic_q) begin
                cnt <= dir_up_q ? '0 : period_q;
                if (pause) begin
                  state_q <= ST_HOLD;
                end
              end else begin
                state_q <= ST_DONE;
                busy    <= 1'b0;
              end
            end else begin
              if (tick) begin
                cnt <= dir_up_q ? (cnt + CNT_W'(1)) : (cnt - CNT_W'(1));
              end
              if (pause) begin
                state_q <= ST_HOLD;
              end
            end
          end
          ST_HOLD: begin
            if (!pause) begin
              state_q <= ST_RUN;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
